// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch block.
// FETCH_JAL_PREDECODE_EN (in fetch_unit) uses OPC_JAL and j_imm from here.
package fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    // Sign-extended J-type immediate (byte offset, bit 0 always zero).
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries with push/pop/flush and occupancy.
// Head outputs read zero while the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] wpc_i,
    input  logic [DATA_W-1:0] winstr_i,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            pc_mem[wr_q]    <= wpc_i;
            instr_mem[wr_q] <= winstr_i;
        end
    end

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign count_o      = count_q;
    assign head_pc_o    = empty_o ? '0 : pc_mem[rd_q];
    assign head_instr_o = empty_o ? '0 : instr_mem[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator feeding decode through a prefetch buffer.
// Define FETCH_JAL_PREDECODE_EN to follow JAL targets without a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [CW-1:0]     fifo_count,
    output logic [1:0]        state_dbg
);

    // Handshake: an entry moves to decode on any cycle where if_valid and
    // id_ready are both high; a redirect in that cycle discards the transfer.

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
    logic              pop, push, fifo_full, fifo_empty;

    assign pop  = if_valid && id_ready;
    assign push = (state_q == S_FETCH) && (!fifo_full || pop) && !redirect_valid;

`ifdef FETCH_JAL_PREDECODE_EN
    assign next_pc = (imem_rdata[6:0] == OPC_JAL) ? pc_q + ADDR_W'(j_imm(imem_rdata))
                                                  : pc_q + ADDR_W'(4);
`else
    assign next_pc = pc_q + ADDR_W'(4);
`endif

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .pop_i        (pop && !redirect_valid),
        .flush_i      (redirect_valid),
        .wpc_i        (pc_q),
        .winstr_i     (imem_rdata),
        .head_pc_o    (if_pc),
        .head_instr_o (if_instr),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HALT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            state_d = en ? S_FETCH : S_HALT;
        end else begin
            if (push) pc_d = next_pc;
            unique case (state_q)
                S_HALT:  if (en) state_d = S_FETCH;
                S_FETCH: begin
                    // Full after this edge with nothing leaving: stop fetching.
                    if (!en)
                        state_d = S_HALT;
                    else if (!pop && (fifo_full || (push && fifo_count == CW'(FIFO_DEPTH - 1))))
                        state_d = S_FULL;
                end
                S_FULL: begin
                    if (!en)      state_d = S_HALT;
                    else if (pop) state_d = S_FETCH;
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = !fifo_empty;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_JAL_PREDECODE_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, id_ready, redirect_valid;
    logic [7:0]  redirect_pc, imem_addr, if_pc;
    logic [31:0] imem_rdata, if_instr;
    logic        if_valid;
    logic [2:0]  fifo_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    logic [31:0] mem [64];
    logic [31:0] prog [18] = '{
        32'h00000013, 32'h00006093, 32'h00100113, 32'h00a00193,
        32'h00000213, 32'h00400293, 32'h00208233, 32'h00328023,
        32'h00010093, 32'h00020113, 32'h00128293, 32'hfff18193,
        32'h00018463, 32'h00000013, 32'h00000013, 32'h00000013,
        32'h00000013, 32'hfd5ff06f
    };

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count),
        .state_dbg      (state_dbg)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_pc;
    state_e      m_st;
    logic [39:0] exp_q[$];
    bit          m_pop, m_push;
    logic [31:0] m_word;

    function automatic logic [7:0] next_pc_of(input logic [7:0] pc, input logic [31:0] w);
        int off;
        off = 4;
        if (JAL_EN && w[6:0] == 7'b1101111)
            off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        return 8'(int'(pc) + off);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 8'h00;
            m_st = S_HALT;
            exp_q.delete();
        end else begin
            m_pop  = (exp_q.size() != 0) && id_ready;
            m_push = (m_st == S_FETCH) && (exp_q.size() < DEPTH || m_pop) && !redirect_valid;
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = {redirect_pc[7:2], 2'b00};
                m_st = en ? S_FETCH : S_HALT;
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) begin
                    m_word = mem[m_pc[7:2]];
                    exp_q.push_back({m_pc, m_word});
                    m_pc = next_pc_of(m_pc, m_word);
                end
                case (m_st)
                    S_HALT:  if (en) m_st = S_FETCH;
                    S_FETCH: if (!en) m_st = S_HALT;
                             else if (exp_q.size() == DEPTH && !m_pop) m_st = S_FULL;
                    S_FULL:  if (!en) m_st = S_HALT;
                             else if (m_pop) m_st = S_FETCH;
                    default: m_st = S_HALT;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("imem_addr", 40'(imem_addr), 40'(m_pc));
            check("fifo_count", 40'(fifo_count), 40'(exp_q.size()));
            check("if_valid", 40'(if_valid), 40'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("head", {if_pc, if_instr}, exp_q[0]);
            else                   check("head_empty", {if_pc, if_instr}, 40'h0);
            check("state", 40'(state_dbg), 40'(m_st));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; en = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 18; i++) mem[i] = prog[i];
        for (int i = 32; i < 63; i++) mem[i] = $urandom;

        tick(); tick();
        check("rst_imem_addr", 40'(imem_addr), 40'h00);
        check("rst_if_valid", 40'(if_valid), 40'h0);
        check("rst_count", 40'(fifo_count), 40'h0);
        check("rst_head", {if_pc, if_instr}, 40'h0);
        check("rst_state", 40'(state_dbg), 40'(S_HALT));
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Sequential fetch, decode always ready
        en = 1'b1; id_ready = 1'b1;
        tick();
        check("a_first_addr", 40'(imem_addr), 40'h00);
        check("a_not_valid", 40'(if_valid), 40'h0);
        tick();
        check("a_head0", {7'h0, if_valid, if_pc, if_instr}, {7'h0, 1'b1, 8'h00, 32'h00000013});
        check("a_addr4", 40'(imem_addr), 40'h04);
        tick();
        check("a_head1", {if_pc, if_instr}, {8'h04, 32'h00006093});

        // Back-pressure fills the buffer, then drains in order
        id_ready = 1'b0;
        do_reset();
        tick();
        repeat (10) tick();
        check("b_count_full", 40'(fifo_count), 40'h4);
        check("b_state_full", 40'(state_dbg), 40'(S_FULL));
        check("b_addr_frozen", 40'(imem_addr), 40'h10);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b_drain", {if_pc, if_instr}, {8'(4 * i), prog[i]});
            tick();
        end

        // Redirect with three entries buffered
        id_ready = 1'b0;
        do_reset();
        tick();
        repeat (3) tick();
        check("c_count3", 40'(fifo_count), 40'h3);
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h1E;
        tick();
        check("c_flushed", {31'h0, if_valid, fifo_count, 5'h0}, 40'h0);
        check("c_target", 40'(imem_addr), 40'h1C);
        redirect_valid = 1'b0;
        tick();
        check("c_first_push", {7'h0, if_valid, if_pc, if_instr}, {7'h0, 1'b1, 8'h1C, 32'h00328023});

        // Asynchronous reset with a full buffer
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h18;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        check("d_full_at_28", {30'h0, fifo_count, imem_addr}, {30'h0, 3'h4, 8'h28});
        #2 rst_n = 1'b0;
        #1;
        check("d_async_count", 40'(fifo_count), 40'h0);
        check("d_async_valid", 40'(if_valid), 40'h0);
        check("d_async_addr", 40'(imem_addr), 40'h00);
        check("d_async_head", {if_pc, if_instr}, 40'h0);
        tick();
        en = 1'b1; id_ready = 1'b1; rst_n = 1'b1;
        tick();
        check("d_resume_addr", 40'(imem_addr), 40'h00);
        tick();
        check("d_resume_head", {if_pc, if_instr}, {8'h00, 32'h00000013});

        // Address wrap from 0xFC
        redirect_valid = 1'b1; redirect_pc = 8'hFC;
        tick();
        check("e_addr_fc", 40'(imem_addr), 40'hFC);
        redirect_valid = 1'b0;
        tick();
        check("e_head_fc", {if_pc, if_instr}, {8'hFC, 32'h0});
        tick();
        check("e_head_wrap", {if_pc, if_instr}, {8'h00, 32'h00000013});

        // JAL at 0x44
        redirect_valid = 1'b1; redirect_pc = 8'h44;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("f_jal_head", {if_pc, if_instr}, {8'h44, 32'hfd5ff06f});
`ifdef FETCH_JAL_PREDECODE_EN
        check("f_jal_next", 40'(imem_addr), 40'h18);
`else
        check("f_jal_next", 40'(imem_addr), 40'h48);
`endif

        // Randomized traffic in bursts of differing back-pressure
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < 400; c++) begin
                en             = ($urandom_range(0, 9) != 0);
                id_ready       = ($urandom_range(0, b) == 0);
                redirect_valid = ($urandom_range(0, 24) == 0);
                redirect_pc    = 8'($urandom_range(0, 255));
                tick();
            end
        end
        redirect_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
